// File: rtl/serial_adder_seq_if.sv
// Operand, result and full-adder connections of the bit-serial adder sequencer.
// The slave side is the sequencer; the master side is its environment, including the full-adder cell.
interface serial_adder_seq_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             op_cin;
   logic             fa_a;
   logic             fa_b;
   logic             fa_cin;
   logic             fa_sum;
   logic             fa_cout;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output in_valid, op_a, op_b, op_cin, out_ready, fa_sum, fa_cout,
      input  in_ready, fa_a, fa_b, fa_cin, out_valid, sum, cout
   );

   modport slave (
      input  in_valid, op_a, op_b, op_cin, out_ready, fa_sum, fa_cout,
      output in_ready, fa_a, fa_b, fa_cin, out_valid, sum, cout
   );
endinterface

// File: rtl/serial_adder_seq.sv
// Bit-serial sequencer around an external 1-bit full adder: shifts operands out LSB first,
// collects sum bits and the running carry, then hands the result off over valid/ready.
module serial_adder_seq #(
   parameter int WIDTH = 8
) (
   input logic               clk,
   input logic               rst_n,
   serial_adder_seq_if.slave bus
);
   localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] sum_sh;
   logic             carry_q;
   logic [CNT_W-1:0] bit_cnt;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             run_q;

   // run_q gates the adder inputs so the cell sees zeros outside RUN.
   assign bus.fa_a      = run_q & a_sh[0];
   assign bus.fa_b      = run_q & b_sh[0];
   assign bus.fa_cin    = run_q & carry_q;
   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.sum       = sum_sh;
   assign bus.cout      = carry_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         a_sh        <= '0;
         b_sh        <= '0;
         sum_sh      <= '0;
         carry_q     <= 1'b0;
         bit_cnt     <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         run_q       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_sh       <= bus.op_a;
                  b_sh       <= bus.op_b;
                  carry_q    <= bus.op_cin;
                  bit_cnt    <= '0;
                  in_ready_q <= 1'b0;
                  run_q      <= 1'b1;
                  state      <= RUN;
               end
            end
            RUN: begin
               sum_sh  <= {bus.fa_sum, sum_sh[WIDTH-1:1]};
               carry_q <= bus.fa_cout;
               a_sh    <= a_sh >> 1;
               b_sh    <= b_sh >> 1;
               // Counter returns to zero on the last bit so it never reaches WIDTH.
               if (bit_cnt == LAST_BIT) begin
                  bit_cnt     <= '0;
                  run_q       <= 1'b0;
                  out_valid_q <= 1'b1;
                  state       <= DONE;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: begin
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               run_q       <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_serial_adder_seq.sv
// Self-checking bench for serial_adder_seq: table vectors, random operands against an
// arithmetic reference, and hand-written backpressure, busy, reset and back-to-back sequences.
module tb_serial_adder_seq;
   localparam int W  = 8;
   localparam int W4 = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   serial_adder_seq_if #(.WIDTH(W))  bus8 ();
   serial_adder_seq_if #(.WIDTH(W4)) bus4 ();

   // Behavioural full-adder cells closing the loop around each sequencer.
   assign bus8.fa_sum  = bus8.fa_a ^ bus8.fa_b ^ bus8.fa_cin;
   assign bus8.fa_cout = (bus8.fa_a & bus8.fa_b) | (bus8.fa_cin & (bus8.fa_a | bus8.fa_b));
   assign bus4.fa_sum  = bus4.fa_a ^ bus4.fa_b ^ bus4.fa_cin;
   assign bus4.fa_cout = (bus4.fa_a & bus4.fa_b) | (bus4.fa_cin & (bus4.fa_a | bus4.fa_b));

   serial_adder_seq #(.WIDTH(W))  dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
   serial_adder_seq #(.WIDTH(W4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] s;
      logic         c;
      int           hold;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W:0] model_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic cin);
      int s;
      s = int'(a) + int'(b) + int'(cin);
      return (W+1)'(s);
   endfunction

   // Carry entering bit i is bit i of the sum of the operands' low i bits plus carry-in.
   function automatic logic [W-1:0] model_carries(input logic [W-1:0] a, input logic [W-1:0] b,
                                                  input logic cin);
      logic [W-1:0] r;
      int mask, s;
      r = '0;
      for (int i = 0; i < W; i++) begin
         mask = (1 << i) - 1;
         s    = (int'(a) & mask) + (int'(b) & mask) + int'(cin);
         r[i] = s[i];
      end
      return r;
   endfunction

   task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
      int waited;
      waited = 0;
      @(negedge clk);
      bus8.in_valid = 1'b1;
      bus8.op_a     = a;
      bus8.op_b     = b;
      bus8.op_cin   = cin;
      while (!bus8.in_ready && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      if (!bus8.in_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 40 cycles");
      end
      @(posedge clk);
      #1 bus8.in_valid = 1'b0;
   endtask

   task automatic collect(output logic [W-1:0] s, output logic c, output int lat,
                          output logic [W-1:0] sa, output logic [W-1:0] sb,
                          output logic [W-1:0] sc);
      lat = -1;
      s   = '0;
      c   = 1'b0;
      sa  = '0;
      sb  = '0;
      sc  = '0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k <= W) begin
            sa[k-1] = bus8.fa_a;
            sb[k-1] = bus8.fa_b;
            sc[k-1] = bus8.fa_cin;
         end
         if (k == 2) check("in_ready_busy", 32'(bus8.in_ready), 32'd0);
         if (bus8.out_valid) begin
            lat = k - 1;
            s   = bus8.sum;
            c   = bus8.cout;
            break;
         end
      end
      if (lat < 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL collect_timeout: out_valid stayed 0, expected 1 within 40 cycles");
      end
   endtask

   task automatic handoff(input int hold, input logic [W-1:0] s_exp, input logic c_exp);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check("bp_out_valid", 32'(bus8.out_valid), 32'd1);
         check("bp_sum", 32'(bus8.sum), 32'(s_exp));
         check("bp_cout", 32'(bus8.cout), 32'(c_exp));
         check("bp_in_ready", 32'(bus8.in_ready), 32'd0);
      end
      bus8.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("post_out_valid", 32'(bus8.out_valid), 32'd0);
      check("post_in_ready", 32'(bus8.in_ready), 32'd1);
      bus8.out_ready = 1'b0;
   endtask

   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic [W-1:0] s_exp, input logic c_exp,
                         input int hold);
      logic [W-1:0] s, sa, sb, sc;
      logic         c;
      int           lat;
      accept(a, b, cin);
      collect(s, c, lat, sa, sb, sc);
      check({tag, "_sum"}, 32'(s), 32'(s_exp));
      check({tag, "_cout"}, 32'(c), 32'(c_exp));
      check({tag, "_latency"}, 32'(lat), 32'(W));
      check({tag, "_fa_a_seq"}, 32'(sa), 32'(a));
      check({tag, "_fa_b_seq"}, 32'(sb), 32'(b));
      check({tag, "_fa_cin_seq"}, 32'(sc), 32'(model_carries(a, b, cin)));
      handoff(hold, s_exp, c_exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] s, sa, sb, sc, ra, rb;
      logic         c, rc;
      logic [W:0]   mdl;
      int           lat;
      logic         got1;
      time          t0, t1;

      vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 0};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0};
      vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1};
      vecs[3] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 5};
      vecs[4] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 0};
      vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 2};
      vecs[6] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 0};
      vecs[7] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1};
      vecs[8] = '{8'hC8, 8'h64, 1'b1, 8'h2D, 1'b1, 0};

      bus8.in_valid = 1'b0; bus8.op_a = '0; bus8.op_b = '0; bus8.op_cin = 1'b0;
      bus8.out_ready = 1'b0;
      bus4.in_valid = 1'b0; bus4.op_a = '0; bus4.op_b = '0; bus4.op_cin = 1'b0;
      bus4.out_ready = 1'b0;

      // Reset state.
      @(negedge clk);
      @(negedge clk);
      check("rst_in_ready", 32'(bus8.in_ready), 32'd1);
      check("rst_out_valid", 32'(bus8.out_valid), 32'd0);
      check("rst_sum", 32'(bus8.sum), 32'd0);
      check("rst_cout", 32'(bus8.cout), 32'd0);
      check("rst_fa", 32'({bus8.fa_a, bus8.fa_b, bus8.fa_cin}), 32'd0);
      check("rst_in_ready_w4", 32'(bus4.in_ready), 32'd1);
      rst_n = 1'b1;

      foreach (vecs[i])
         run_op("vec", vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].c, vecs[i].hold);

      for (int i = 0; i < 20; i++) begin
         ra  = W'($urandom);
         rb  = W'($urandom);
         rc  = 1'($urandom);
         mdl = model_add(ra, rb, rc);
         run_op("rnd", ra, rb, rc, mdl[W-1:0], mdl[W], int'($urandom_range(0, 2)));
      end

      // in_valid during RUN and DONE must not disturb the running operation.
      accept(8'h5A, 8'h3C, 1'b0);
      @(negedge clk);
      @(negedge clk);
      bus8.in_valid = 1'b1; bus8.op_a = 8'hAA; bus8.op_b = 8'h55; bus8.op_cin = 1'b0;
      @(negedge clk);
      bus8.in_valid = 1'b0;
      collect(s, c, lat, sa, sb, sc);
      check("busy_first_sum", 32'(s), 32'h96);
      check("busy_first_cout", 32'(c), 32'd0);
      bus8.in_valid = 1'b1;
      check("busy_done_in_ready", 32'(bus8.in_ready), 32'd0);
      handoff(0, 8'h96, 1'b0);
      @(posedge clk);
      #1 bus8.in_valid = 1'b0;
      collect(s, c, lat, sa, sb, sc);
      check("busy_second_sum", 32'(s), 32'hFF);
      check("busy_second_cout", 32'(c), 32'd0);
      check("busy_second_latency", 32'(lat), 32'(W));
      handoff(0, 8'hFF, 1'b0);

      // Reset in the middle of RUN, then a clean operation afterwards.
      for (int r = 0; r < 2; r++) begin
         if (r == 0) accept(8'h80, 8'h80, 1'b0);
         else        accept(8'h0F, 8'h00, 1'b1);
         repeat (4) @(negedge clk);
         rst_n = 1'b0;
         #1;
         check("midrst_out_valid", 32'(bus8.out_valid), 32'd0);
         check("midrst_in_ready", 32'(bus8.in_ready), 32'd1);
         check("midrst_fa", 32'({bus8.fa_a, bus8.fa_b, bus8.fa_cin}), 32'd0);
         check("midrst_sum", 32'(bus8.sum), 32'd0);
         check("midrst_cout", 32'(bus8.cout), 32'd0);
         @(negedge clk);
         rst_n = 1'b1;
         run_op("after_rst", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 0);
      end

      // Back-to-back on the 4-bit instance with in_valid held high.
      bus4.out_ready = 1'b1;
      @(negedge clk);
      bus4.in_valid = 1'b1; bus4.op_a = 4'hF; bus4.op_b = 4'h1; bus4.op_cin = 1'b0;
      @(posedge clk);
      t0 = $time;
      #1 bus4.op_a = 4'h7; bus4.op_b = 4'h8;
      got1 = 1'b0;
      t1   = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (bus4.out_valid && !got1) begin
            got1 = 1'b1;
            check("b2b_first_sum", 32'(bus4.sum), 32'h0);
            check("b2b_first_cout", 32'(bus4.cout), 32'd1);
         end
         if (got1 && bus4.in_ready) begin
            @(posedge clk);
            t1 = $time;
            #1 bus4.in_valid = 1'b0;
            break;
         end
      end
      check("b2b_first_seen", 32'(got1), 32'd1);
      check("b2b_accept_spacing", 32'(int'((t1 - t0) / 10)), 32'(W4 + 2));
      got1 = 1'b0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (bus4.out_valid) begin
            got1 = 1'b1;
            check("b2b_second_sum", 32'(bus4.sum), 32'hF);
            check("b2b_second_cout", 32'(bus4.cout), 32'd0);
            break;
         end
      end
      check("b2b_second_seen", 32'(got1), 32'd1);
      bus4.in_valid  = 1'b0;
      bus4.out_ready = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/serial_adder_seq.md
# serial_adder_seq

Bit-serial sequencer for the team's 1-bit full-adder stage. It accepts two WIDTH-bit operands plus a carry-in over a valid/ready handshake, and presents one bit pair per cycle, LSB first, to the full adder (fa_a, fa_b, fa_cin). It captures the adder's sum and carry back each cycle and delivers the WIDTH-bit sum and final carry over a second valid/ready handshake. It sits directly around the full-adder cell: upstream of its inputs and downstream of its outputs.

## Interface

- WIDTH, 8, operand/sum width in bits; legal range 2..16.

- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  operand request valid.
- in_ready  out  1  block can accept operands (high only in IDLE).
- op_a  in  WIDTH  operand A; sampled on the accept edge.
- op_b  in  WIDTH  operand B; sampled on the accept edge.
- op_cin  in  1  carry-in; sampled on the accept edge.
- fa_a  out  1  bit of A to the full adder.
- fa_b  out  1  bit of B to the full adder.
- fa_cin  out  1  running carry to the full adder.
- fa_sum  in  1  full-adder sum; combinational from fa_a/fa_b/fa_cin.
- fa_cout  in  1  full-adder carry-out; combinational.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- sum  out  WIDTH  result sum.
- cout  out  1  final carry-out.

## Operation

- **States:** IDLE, RUN, DONE. State is binary-encoded; the encoding is free.
- **IDLE**
  - in_ready=1.
  - Accept when in_valid=1:
    - load a_sh←op_a, b_sh←op_b, carry_q←op_cin, bit_cnt←0;
    - go RUN.
- **RUN**
  - in_ready=0. in_valid is ignored.
  - Combinational outputs: fa_a=a_sh[0], fa_b=b_sh[0], fa_cin=carry_q.
  - Each edge:
    - sum_sh←{fa_sum, sum_sh[WIDTH-1:1]};
    - carry_q←fa_cout;
    - a_sh and b_sh shift right by 1 with zero fill;
    - bit_cnt+1.
  - On the edge where bit_cnt==WIDTH-1, go DONE.
- **DONE**
  - out_valid=1.
  - sum=sum_sh and cout=carry_q are held stable.
  - When out_ready=1, go IDLE.
  - There is no direct DONE→RUN transition. New operands are accepted only in IDLE.
- **Outside RUN:** fa_a=fa_b=fa_cin=0.
- **sum/cout outside DONE:**
  - They reflect the internal registers.
  - They are meaningful only while out_valid=1.
  - In IDLE they keep the last result until the next accept.
- **Arithmetic:** {cout,sum} = op_a + op_b + op_cin, exact over WIDTH+1 bits, no saturation.
- **bit_cnt:** width is clog2(WIDTH); it never exceeds WIDTH-1.
- **Reset (rst_n=0, any time, including mid-RUN):**
  - state→IDLE;
  - a_sh, b_sh, sum_sh, carry_q, bit_cnt→0;
  - in-flight operation is discarded and no partial result is emitted.
- **Output values during reset:** in_ready=1, out_valid=0, sum=0, cout=0, fa_a/fa_b/fa_cin=0.

## Timing

- Let E0 be the rising edge where in_valid&in_ready=1.
- **Bit presentation:** bit i (i=0..WIDTH-1) is presented on fa_* in the cycle between E0+i and E0+i+1.
- **Result:** out_valid rises after edge E0+WIDTH, i.e. latency WIDTH cycles.
- **Result handoff:** the result is consumed on the first edge with out_valid&out_ready=1. out_valid is low after that edge, and in_ready is high.
- **Throughput:** minimum one operation per WIDTH+2 cycles (accept, WIDTH RUN cycles, DONE handoff).
- **Backpressure:** with out_ready=0, DONE holds indefinitely. out_valid, sum and cout must not change.
- **in_valid while busy:** in_valid high during RUN or DONE is not accepted. Upstream must hold op_* until in_ready.
- **Full-adder path:** fa_sum and fa_cout must settle within the same cycle; the block adds no pipeline stage on that path.
- **Reset timing:** rst_n deassertion is synchronised externally. The first accept is possible on the first edge after release.

## Test plan

- **Basic add:** WIDTH=8, op_a=0x5A, op_b=0x3C, op_cin=0, out_ready=1 → out_valid exactly 8 cycles after accept, sum=0x96, cout=0. fa_a sequence LSB-first is 0,1,0,1,1,0,1,0.
- **Carry ripple:** op_a=0xFF, op_b=0x01, cin=0 → sum=0x00, cout=1. Then op_a=0xFF, op_b=0xFF, cin=1 → sum=0xFF, cout=1. Also check fa_cin=1 on bits 1..7 of the first operation.
- **Backpressure:** 0x12+0x34 with out_ready=0 for 5 cycles in DONE → out_valid stays 1, sum=0x46 stable, in_ready=0. Raise out_ready → one handoff, then in_ready=1 next cycle.
- **Busy input ignored:** pulse in_valid with op_a=0xAA, op_b=0x55 during RUN → no effect; first result unchanged. The new pair is accepted only after return to IDLE and yields 0xFF, cout=0.
- **Reset mid-RUN:** assert rst_n=0 after bit 3 of 0x80+0x80 → immediately out_valid=0, in_ready=1, fa_*=0, sum=0. After release, 0x80+0x80 gives sum=0x00, cout=1 with correct latency.
- **Back-to-back, WIDTH=4:** ops 0xF+0x1 and 0x7+0x8 with in_valid held high → results 0x0/cout=1, then 0xF/cout=0. Accepts are spaced by 6 cycles (WIDTH+2).
